// File: rtl/mem_access_arbiter_pkg.sv
// Shared types for the fetch/data arbiter in front of MainMem.
// CPU access type, MainMem port bundles and arbiter-local enums.
package PkgFrost32Cpu;
  typedef enum logic {
    DiatRead  = 1'b0,
    DiatWrite = 1'b1
  } DataInoutAccessType;
endpackage

package PkgMainMem;
  import PkgFrost32Cpu::*;

  typedef struct packed {
    logic               req_mem_access;
    logic [31:0]        addr;
    logic [31:0]        data;
    DataInoutAccessType data_inout_access_type;
  } PortIn_MainMem;

  typedef struct packed {
    logic        wait_for_mem;
    logic [31:0] data;
  } PortOut_MainMem;
endpackage

package PkgMemArbiter;
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } StateT;

  typedef enum logic {
    PsIfetch = 1'b0,
    PsData   = 1'b1
  } PortSelT;

  localparam int WordW = 32;

  function automatic PortSelT other_port(input PortSelT p);
    return (p == PsData) ? PsIfetch : PsData;
  endfunction
endpackage

// File: rtl/mem_access_arbiter_rr.sv
// Two-request round-robin picker: remembers the last winner
// and favours the other port when both request.
module mem_rr_picker2
  import PkgMemArbiter::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    in_req_ifetch,
  input  logic    in_req_data,
  input  logic    in_advance,
  output logic    out_valid,
  output PortSelT out_sel
);

  PortSelT last_q;
  PortSelT last_d;

  always_comb begin
    out_valid = in_req_ifetch | in_req_data;
    out_sel   = PsIfetch;
    unique case (1'b1)
      in_req_ifetch && in_req_data:
        out_sel = other_port(last_q);
      in_req_data && !in_req_ifetch:
        out_sel = PsData;
      default:
        out_sel = PsIfetch;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (in_advance) begin
      last_d = out_sel;
    end
  end

  // Reset as if fetch won last, so data has first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= PsIfetch;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter between CPU fetch and data ports and
// the single MainMem request port, with a wait watchdog.
module mem_access_arbiter
  import PkgFrost32Cpu::*;
  import PkgMainMem::*;
  import PkgMemArbiter::*;
#(
  parameter int TIMEOUT_CYCLES    = 64,
  parameter int TIMEOUT_CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_ifetch_req,
  input  logic [31:0]    in_ifetch_addr,
  output logic           out_ifetch_ack,
  output logic [31:0]    out_ifetch_data,
  input  logic           in_data_req,
  input  logic [31:0]    in_data_addr,
  input  logic           in_data_we,
  input  logic [31:0]    in_data_wdata,
  output logic           out_data_ack,
  output logic [31:0]    out_data_rdata,
  output PortIn_MainMem  out_mm,
  input  PortOut_MainMem in_mm,
  output logic           out_busy,
  output logic           out_timeout
);

  localparam logic [TIMEOUT_CNT_WIDTH-1:0] CntLimit =
    TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES);

  StateT   state_q, state_d;
  PortSelT winner_q, winner_d;

  logic [WordW-1:0] addr_q, addr_d;
  logic [WordW-1:0] wdata_q, wdata_d;
  DataInoutAccessType type_q, type_d;

  logic [WordW-1:0] ifetch_data_q, ifetch_data_d;
  logic [WordW-1:0] data_rdata_q, data_rdata_d;

  logic [TIMEOUT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [TIMEOUT_CNT_WIDTH-1:0] cnt_inc;
  logic timeout_q, timeout_d;

  logic       pick_valid;
  PortSelT    pick_sel;
  logic       advance;
  logic       cap_en;
  logic [WordW-1:0] cap_word;

  mem_rr_picker2 u_picker (
    .clk          (clk),
    .rst          (rst),
    .in_req_ifetch(in_ifetch_req),
    .in_req_data  (in_data_req),
    .in_advance   (advance),
    .out_valid    (pick_valid),
    .out_sel      (pick_sel)
  );

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    type_d    = type_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    advance   = 1'b0;
    cap_en    = 1'b0;
    cap_word  = '0;

    unique case (state_q)
      StIdle: begin
        // Never start while MainMem still finishes an old access.
        if (pick_valid && !in_mm.wait_for_mem) begin
          advance  = 1'b1;
          winner_d = pick_sel;
          if (pick_sel == PsData) begin
            addr_d  = in_data_addr;
            wdata_d = in_data_wdata;
            type_d  = in_data_we ? DiatWrite : DiatRead;
          end else begin
            addr_d  = in_ifetch_addr;
            wdata_d = '0;
            type_d  = DiatRead;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (!in_mm.wait_for_mem) begin
          cap_en   = 1'b1;
          cap_word = (type_q == DiatWrite) ? '0 : in_mm.data;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntLimit) begin
            cap_en    = 1'b1;
            cap_word  = '0;
            timeout_d = 1'b1;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    ifetch_data_d = ifetch_data_q;
    data_rdata_d  = data_rdata_q;
    if (cap_en) begin
      if (winner_q == PsData) begin
        data_rdata_d = cap_word;
      end else begin
        ifetch_data_d = cap_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      winner_q      <= PsIfetch;
      addr_q        <= '0;
      wdata_q       <= '0;
      type_q        <= DiatRead;
      ifetch_data_q <= '0;
      data_rdata_q  <= '0;
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      type_q        <= type_d;
      ifetch_data_q <= ifetch_data_d;
      data_rdata_q  <= data_rdata_d;
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    out_mm.req_mem_access         = (state_q == StIssue);
    out_mm.addr                   = addr_q;
    out_mm.data                   = wdata_q;
    out_mm.data_inout_access_type = type_q;
  end

  assign out_ifetch_ack  = (state_q == StDone) &&
                           (winner_q == PsIfetch);
  assign out_data_ack    = (state_q == StDone) &&
                           (winner_q == PsData);
  assign out_ifetch_data = ifetch_data_q;
  assign out_data_rdata  = data_rdata_q;
  assign out_busy        = (state_q != StIdle);
  assign out_timeout     = timeout_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter with a behavioural MainMem
// (three extra wait cycles) and an ack scoreboard.
module tb_mem_access_arbiter;
  import PkgFrost32Cpu::*;
  import PkgMainMem::*;
  import PkgMemArbiter::*;

  localparam int TO = 10;

  logic clk = 1'b0;
  logic rst;
  logic in_ifetch_req;
  logic [31:0] in_ifetch_addr;
  logic out_ifetch_ack;
  logic [31:0] out_ifetch_data;
  logic in_data_req;
  logic [31:0] in_data_addr;
  logic in_data_we;
  logic [31:0] in_data_wdata;
  logic out_data_ack;
  logic [31:0] out_data_rdata;
  PortIn_MainMem out_mm;
  PortOut_MainMem in_mm;
  logic out_busy;
  logic out_timeout;

  mem_access_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_ifetch_req  (in_ifetch_req),
    .in_ifetch_addr (in_ifetch_addr),
    .out_ifetch_ack (out_ifetch_ack),
    .out_ifetch_data(out_ifetch_data),
    .in_data_req    (in_data_req),
    .in_data_addr   (in_data_addr),
    .in_data_we     (in_data_we),
    .in_data_wdata  (in_data_wdata),
    .out_data_ack   (out_data_ack),
    .out_data_rdata (out_data_rdata),
    .out_mm         (out_mm),
    .in_mm          (in_mm),
    .out_busy       (out_busy),
    .out_timeout    (out_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          port;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  logic [31:0] mem [logic [31:0]];
  int mm_cnt = 0;
  logic [31:0] mm_rdata = '0;
  bit stuck = 1'b0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  assign in_mm = '{
    wait_for_mem: out_mm.req_mem_access || (mm_cnt != 0) || stuck,
    data: mm_rdata
  };

  always @(posedge clk) begin
    if (out_mm.req_mem_access) begin
      mm_cnt <= 3;
    end else if (mm_cnt != 0) begin
      mm_cnt <= mm_cnt - 1;
      if (mm_cnt == 1) begin
        mm_rdata <= rd(out_mm.addr);
        if (out_mm.data_inout_access_type == DiatWrite)
          mem[out_mm.addr] = out_mm.data;
      end
    end
  end

  int pulses = 0;
  bit in_txn = 0;
  bit stab_bad = 0;
  logic [64:0] snap;

  always @(negedge clk) begin
    if (rst) begin
      pulses   = 0;
      in_txn   = 0;
      stab_bad = 0;
    end else begin
      if (out_mm.req_mem_access) begin
        pulses++;
        in_txn = 1;
        snap = {out_mm.addr, out_mm.data,
                out_mm.data_inout_access_type};
      end else if (in_txn && out_busy &&
                   {out_mm.addr, out_mm.data,
                    out_mm.data_inout_access_type} != snap) begin
        stab_bad = 1;
      end
      if (out_ifetch_ack && out_data_ack) begin
        chk("double_ack", 1, 0);
      end else if (out_ifetch_ack || out_data_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", {out_ifetch_ack, out_data_ack}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_port", out_data_ack, e.port);
          chk("ack_data", out_data_ack ? out_data_rdata
                                       : out_ifetch_data, e.data);
          chk("req_pulse_cnt", pulses, 1);
          chk("mm_stable", stab_bad, 0);
        end
        pulses   = 0;
        in_txn   = 0;
        stab_bad = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string name);
    int lat = -1;
    in_data_we    = v.we;
    in_data_wdata = v.wdata;
    if (v.port) begin
      in_data_addr = v.addr;
      in_data_req  = 1'b1;
    end else begin
      in_ifetch_addr = v.addr;
      in_ifetch_req  = 1'b1;
    end
    sb.push_back('{port: v.port, data: v.exp});
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (v.port ? out_data_ack : out_ifetch_ack) begin
        lat = k;
        break;
      end
    end
    tick();
    in_ifetch_req = 1'b0;
    in_data_req   = 1'b0;
    chk(name, lat, v.lat);
  endtask

  task automatic dual(input int n_i, input int n_d,
                      input logic [31:0] a_i, input logic [31:0] a_d,
                      input int exp_last, input string name);
    int ci = 0;
    int cd = 0;
    int last = -1;
    bit hi, hd;
    in_ifetch_addr = a_i;
    in_data_addr   = a_d;
    in_data_we     = 1'b0;
    in_data_wdata  = '0;
    in_ifetch_req  = (n_i > 0);
    in_data_req    = (n_d > 0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      hi = out_ifetch_ack;
      hd = out_data_ack;
      if (hi) ci++;
      if (hd) cd++;
      if (ci >= n_i && cd >= n_d) begin
        last = k;
        break;
      end
      tick();
      in_ifetch_req = !hi && (ci < n_i);
      in_data_req   = !hd && (cd < n_d);
    end
    tick();
    in_ifetch_req = 1'b0;
    in_data_req   = 1'b0;
    chk(name, last, exp_last);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "bench timeout");
  end

  vec_t vt[$];

  initial begin
    int t_a, t_b, iss;
    bit bad;

    vt.push_back('{0, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 6});
    vt.push_back('{1, 1, 32'h0000_0020, 32'h1234_5678, 32'h0,         6});
    vt.push_back('{1, 0, 32'h0000_0020, 32'hBAD0_BAD0, 32'h1234_5678, 6});
    vt.push_back('{0, 0, 32'h0000_0024, 32'h0,         32'hCAFE_F00D, 6});
    vt.push_back('{1, 0, 32'h0000_0040, 32'h5555_AAAA, 32'h0,         6});
    vt.push_back('{1, 1, 32'h0000_0030, 32'hFFFF_FFFF, 32'h0,         6});
    vt.push_back('{0, 0, 32'h0000_0030, 32'h0,         32'hFFFF_FFFF, 6});
    vt.push_back('{1, 1, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 32'h0,         6});
    vt.push_back('{0, 0, 32'hFFFF_FFFC, 32'h0,         32'hA5A5_5A5A, 6});

    mem[32'h0000_0010] = 32'hDEAD_BEEF;
    mem[32'h0000_0024] = 32'hCAFE_F00D;

    in_ifetch_req  = 1'b0;
    in_ifetch_addr = '0;
    in_data_req    = 1'b0;
    in_data_addr   = '0;
    in_data_we     = 1'b0;
    in_data_wdata  = '0;
    reset_dut();

    @(negedge clk);
    chk("rst_mm_addr", out_mm.addr, 0);
    chk("rst_mm_data", out_mm.data, 0);
    chk("rst_mm_ctl", {out_mm.req_mem_access,
                       out_mm.data_inout_access_type}, 0);
    chk("rst_acks", {out_ifetch_ack, out_data_ack}, 0);
    chk("rst_rdata", {out_ifetch_data, out_data_rdata}, 0);
    chk("rst_status", {out_busy, out_timeout}, 0);
    tick();

    foreach (vt[i]) run_txn(vt[i], $sformatf("vec%0d_lat", i));

    // Both ports requesting from reset: data first, then alternate.
    reset_dut();
    sb.push_back('{1, 32'h1234_5678});
    sb.push_back('{0, 32'hDEAD_BEEF});
    sb.push_back('{1, 32'h1234_5678});
    sb.push_back('{0, 32'hDEAD_BEEF});
    dual(2, 2, 32'h10, 32'h20, 27, "rr4_last_ack");

    // Data won twice, so fetch must win a simultaneous request.
    run_txn('{1, 0, 32'h20, 32'h0, 32'h1234_5678, 6}, "d_only1");
    run_txn('{1, 0, 32'h24, 32'h0, 32'hCAFE_F00D, 6}, "d_only2");
    sb.push_back('{0, 32'hDEAD_BEEF});
    sb.push_back('{1, 32'h1234_5678});
    dual(1, 1, 32'h10, 32'h20, 13, "rr_fetch_first");

    // Fetch request raised in the data StDone cycle.
    t_a = -1;
    t_b = -1;
    in_data_addr   = 32'h20;
    in_data_we     = 1'b0;
    in_ifetch_addr = 32'h24;
    in_data_req    = 1'b1;
    sb.push_back('{1, 32'h1234_5678});
    sb.push_back('{0, 32'hCAFE_F00D});
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_data_ack) t_a = k;
      if (out_ifetch_ack) begin
        t_b = k;
        break;
      end
      tick();
      if (k == 5) in_ifetch_req = 1'b1;
      if (k == t_a) in_data_req = 1'b0;
    end
    tick();
    in_ifetch_req = 1'b0;
    in_data_req   = 1'b0;
    chk("done_hand_data_ack", t_a, 6);
    chk("done_hand_fetch_ack", t_b, 13);

    // Watchdog abort with MainMem wait stuck high.
    t_a = -1;
    in_ifetch_addr = 32'h10;
    in_ifetch_req  = 1'b1;
    sb.push_back('{0, 32'h0});
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (out_ifetch_ack) begin
        t_a = k;
        break;
      end
      tick();
      if (k == 0) stuck = 1'b1;
    end
    tick();
    in_ifetch_req = 1'b0;
    chk("timeout_ack_lat", t_a, TO + 2);
    @(negedge clk);
    chk("timeout_flag", out_timeout, 1);
    chk("timeout_data", out_ifetch_data, 0);
    tick();
    bad = 0;
    in_data_addr = 32'h20;
    in_data_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_busy || out_mm.req_mem_access) bad = 1;
      tick();
    end
    in_data_req = 1'b0;
    chk("no_grant_while_wait", bad, 0);
    stuck = 1'b0;
    tick();
    run_txn('{0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 6}, "post_abort_lat");
    chk("timeout_sticky", out_timeout, 1);
    reset_dut();
    @(negedge clk);
    chk("timeout_cleared", out_timeout, 0);
    tick();

    // Reset in the middle of a read, MainMem still busy.
    t_a = -1;
    iss = -1;
    in_data_addr = 32'h20;
    in_data_we   = 1'b0;
    in_data_req  = 1'b1;
    sb.push_back('{1, 32'h1234_5678});
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 4)
        chk("rst_mid_idle", {out_busy, out_mm.req_mem_access,
                             out_data_ack}, 0);
      if (k > 3 && iss < 0 && out_mm.req_mem_access) iss = k;
      if (out_data_ack) begin
        t_a = k;
        break;
      end
      tick();
      if (k == 2) rst = 1'b1;
      if (k == 3) rst = 1'b0;
    end
    tick();
    in_data_req = 1'b0;
    chk("rst_mid_reissue", iss, 6);
    chk("rst_mid_ack", t_a, 11);

    tick();
    tick();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Two-port arbiter between the Frost32 CPU's instruction-fetch and data-access ports and the single request port of `MainMem`. It sits directly upstream of `MainMem`. It accepts word requests from either CPU port and selects one with round-robin priority. It drives `MainMem` through its one-cycle request / `wait_for_mem` handshake, holding address and data stable for the whole transaction, then returns a one-cycle acknowledge with the read data to the winning port. A watchdog aborts transactions that `MainMem` never completes.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum number of WAIT cycles before an abort.
- TIMEOUT_CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1): width of the watchdog counter.

Ports:
- clk  in  1  sole clock; all logic is on the posedge.
- rst  in  1  synchronous, active-high reset.
- in_ifetch_req  in  1  fetch request; held high until the ack is sampled.
- in_ifetch_addr  in  32  fetch byte address.
- out_ifetch_ack  out  1  one-cycle pulse: fetch complete.
- out_ifetch_data  out  32  fetched word; held until the next fetch ack.
- in_data_req  in  1  data request; same hold rule as fetch.
- in_data_addr  in  32  data byte address.
- in_data_we  in  1  1 = write, 0 = read.
- in_data_wdata  in  32  write word.
- out_data_ack  out  1  one-cycle pulse: data access complete.
- out_data_rdata  out  32  read word (0 after a write); held until the next data ack.
- out_mm  out  PkgMainMem::PortIn_MainMem  fields `req_mem_access`, `addr`, `data`, `data_inout_access_type`.
- in_mm  in  PkgMainMem::PortOut_MainMem  fields `wait_for_mem`, `data`.
- out_busy  out  1  high whenever state ≠ StIdle.
- out_timeout  out  1  sticky abort flag; cleared only by rst.

## Operation
State machine states: StIdle, StIssue, StWait, StDone.

StIdle:
- Grant only if some req is high and `in_mm.wait_for_mem` == 0. This guards against a `MainMem` transaction that was left running when the arbiter was reset.
- With one requester, grant it.
- With both, grant the port that did not win last. After reset, the data port wins.
- On grant: latch addr, wdata and access type into the `out_mm` registers, record the winner, flip the priority bit, go to StIssue.
- Fetch requests are always DiatRead, with `data` = 0.

StIssue:
- `out_mm.req_mem_access` = 1 for exactly this cycle.
- Go to StWait and clear the watchdog counter.

StWait:
- `req_mem_access` = 0.
- If `in_mm.wait_for_mem` == 0, capture `in_mm.data` (or 0 for a write) and go to StDone.
- Otherwise increment the watchdog. When it reaches TIMEOUT_CYCLES, capture 0, set `out_timeout`, and go to StDone.

StDone:
- Pulse the winner's ack with the captured word.
- Go to StIdle.
- Requesters deassert req at the edge that ends StDone, so StIdle never regrants a completed request.

General rules:
- `out_mm.addr`, `data` and `data_inout_access_type` stay constant from StIssue through StDone, because `MainMem` resamples `addr`/`data` mid-transaction. They keep their last values in StIdle.
- Addresses pass through unmodified; alignment and wrap are handled by `MainMem`.

## Timing
- Nominal `MainMem` (3-count sequence), req high in StIdle at cycle 0:
  - StIssue at cycle 1.
  - `wait_for_mem` high in cycles 1–4 and low in cycle 5.
  - Ack in cycle 6.
  - Throughput is one access per 7 cycles.
- Reset values:
  - state StIdle, priority = data.
  - All `out_mm` fields 0 (type DiatRead).
  - Both acks 0, both data outputs 0.
  - `out_busy` 0, `out_timeout` 0.
- rst during any state: next cycle is StIdle with `req_mem_access` 0 and no ack.
- A req arriving during StDone of the other port is granted in the following StIdle.
- Simultaneous reqs in StIdle: exactly one ack per transaction, never two acks in one cycle.
- A port whose req drops before grant is not served. Dropping req after grant is a protocol violation; the transaction still completes.

## Structure
- Package `PkgMemArbiter`:
  - state enum StIdle/StIssue/StWait/StDone.
  - port-select enum PsIfetch/PsData.
- The access type reuses the PkgFrost32Cpu access-type enum (DiatRead/DiatWrite).
- One sub-module: `mem_rr_picker2`, a two-request round-robin picker with a registered last-winner bit and an advance strobe.
- The FSM, latches and watchdog live in the top module.

## Test plan
- Fetch only, addr 0x0000_0010, memory word 0xDEAD_BEEF → ack in cycle 6, `out_ifetch_data` = 0xDEAD_BEEF, `req_mem_access` high exactly 1 cycle.
- Data write of 0x1234_5678 to 0x20, then data read of 0x20 → write ack with `out_data_rdata` = 0; read ack returns 0x1234_5678; `out_mm.addr` constant across each transaction.
- Both reqs high from reset, repeated → order data, fetch, data, fetch; 4 acks in 28 cycles.
- `in_mm` stubbed with `wait_for_mem` stuck at 1 → abort after TIMEOUT_CYCLES WAIT cycles with ack and data 0, `out_timeout` = 1 and held.
- rst asserted in cycle 3 of a read → StIdle next cycle; no ack; no new request issued until `wait_for_mem` falls.
- Fetch req raised in the data port's StDone cycle → fetch granted in the next cycle, ack 7 cycles after the data ack.
